// File: rtl/softmax_exp_accumulator.sv
// rtl/softmax_exp_accumulator.sv - buffers a logit vector, converts to base-2 pseudo-exponentials, sums and streams them
module softmax_exp_accumulator #(
  parameter int N     = 8,
  parameter int LOG2N = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_data,
  output logic                 sum_valid,
  output logic [8+LOG2N-1:0]   sum_full,
  output logic [7:0]           sum_q,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_data,
  output logic                 out_last,
  output logic                 busy
);

  localparam int SW = 8 + LOG2N;

  typedef enum logic [1:0] {S_LOAD, S_EXP, S_SUM, S_EMIT} state_t;

  state_t             state_q, state_d;
  logic [7:0]         mem [N];
  logic [LOG2N-1:0]   idx_q;
  logic [7:0]         max_q;
  logic [SW-1:0]      acc_q;
  logic [SW-1:0]      sum_reg;
  logic               gap_q;
  logic               last_idx, accept, beat;
  logic [7:0]         d, m, e;
  logic [3:0]         k, f;

  assign last_idx  = (idx_q == LOG2N'(N - 1));
  // gap_q holds input off for one cycle after a vector drains, so vectors repeat every 3N+2 cycles
  assign in_ready  = (state_q == S_LOAD) && !gap_q;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_EMIT);
  assign beat      = out_valid && out_ready;
  assign out_data  = out_valid ? mem[idx_q] : 8'd0;
  assign out_last  = out_valid && last_idx;
  assign sum_valid = (state_q == S_SUM);
  assign sum_full  = sum_reg;
  assign sum_q     = sum_reg[LOG2N +: 8];
  assign busy      = !((state_q == S_LOAD) && (idx_q == '0));

  // Piecewise-linear 2^-(d): fraction sets the mantissa, integer part shifts it down
  assign d = max_q - mem[idx_q];
  assign k = d[7:4];
  assign f = d[3:0];
  assign m = 8'd255 - {1'b0, f, 3'b000};
  assign e = k[3] ? 8'd0 : (m >> k[2:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_LOAD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:  if (accept && last_idx) state_d = S_EXP;
      S_EXP:   if (last_idx) state_d = S_SUM;
      S_SUM:   state_d = S_EMIT;
      S_EMIT:  if (beat && last_idx) state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      max_q   <= 8'd0;
      acc_q   <= '0;
      sum_reg <= '0;
      gap_q   <= 1'b0;
    end else begin
      gap_q <= 1'b0;
      case (state_q)
        S_LOAD: begin
          if (accept) begin
            if (in_data > max_q) max_q <= in_data;
            idx_q <= idx_q + 1'b1;
            if (last_idx) acc_q <= '0;
          end
        end
        S_EXP: begin
          acc_q <= acc_q + SW'(e);
          idx_q <= idx_q + 1'b1;
          if (last_idx) sum_reg <= acc_q + SW'(e);
        end
        S_EMIT: begin
          if (beat) begin
            idx_q <= idx_q + 1'b1;
            if (last_idx) begin
              max_q <= 8'd0;
              gap_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Buffer holds logits during LOAD and is overwritten in place by exponentials during EXP
  always_ff @(posedge clk) begin
    if (accept)                 mem[idx_q] <= in_data;
    else if (state_q == S_EXP)  mem[idx_q] <= e;
  end

endmodule

// File: tb/tb_softmax_exp_accumulator.sv
// tb/tb_softmax_exp_accumulator.sv - scoreboard bench for softmax_exp_accumulator
module tb_softmax_exp_accumulator;
  localparam int N = 8;
  localparam int LOG2N = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'd0;
  logic        sum_valid;
  logic [10:0] sum_full;
  logic [7:0]  sum_q;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic        out_last;
  logic        busy;

  softmax_exp_accumulator #(.N(N), .LOG2N(LOG2N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .sum_valid(sum_valid), .sum_full(sum_full), .sum_q(sum_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accepts = 0;
  int last_acc_cyc = 0;
  int bp_mode = 0;
  logic [8:0]  exp_out_q[$];
  logic [10:0] exp_sum_q[$];
  int          exp_time_q[$];
  int          sum_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  task automatic send_vec(input logic [63:0] v, input logic [63:0] e, input int s, input bit hold);
    for (int i = 0; i < N; i++) exp_out_q.push_back({(i == N - 1), e[i*8 +: 8]});
    exp_sum_q.push_back(s[10:0]);
    for (int i = 0; i < N; i++) begin
      int g = 0;
      in_valid = 1'b1;
      in_data  = v[i*8 +: 8];
      while (!in_ready && g < 200) begin
        @(posedge clk); #1;
        g++;
      end
      if (g >= 200) timeout_fail("in_ready_wait");
      last_acc_cyc = cyc;
      @(posedge clk); #1;
    end
    exp_time_q.push_back(last_acc_cyc + N + 1);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((exp_out_q.size() != 0 || exp_sum_q.size() != 0 || busy) && g < 500) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 500) timeout_fail("drain_wait");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_sum_valid"}, sum_valid, 0);
    check({tag, "_sum_full"}, sum_full, 0);
    check({tag, "_sum_q"}, sum_q, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin : ready_driver
    logic [3:0] pat;
    int ph;
    pat = 4'b1001;
    ph = 0;
    forever begin
      @(posedge clk); #1;
      if (bp_mode != 0) begin
        out_ready = pat[3 - ph];
        ph = (ph + 1) % 4;
      end else begin
        out_ready = 1'b1;
        ph = 0;
      end
    end
  end

  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'd0;

  always @(negedge clk) begin : monitor
    if (rst_n) begin
      if (in_valid && in_ready) accepts++;
      if (sum_valid) begin
        sum_cyc.push_back(cyc);
        if (exp_sum_q.size() == 0) begin
          timeout_fail("unexpected_sum_valid");
        end else begin
          logic [10:0] s;
          s = exp_sum_q.pop_front();
          check("sum_full", sum_full, s);
          check("sum_q", sum_q, s >> LOG2N);
        end
        if (exp_time_q.size() != 0) check("sum_latency", cyc, exp_time_q.pop_front());
      end
      if (out_valid) begin
        if (prev_stall) check("stall_hold_data", out_data, prev_data);
        if (out_ready) begin
          if (exp_out_q.size() == 0) begin
            timeout_fail("unexpected_out_beat");
          end else begin
            logic [8:0] x;
            x = exp_out_q.pop_front();
            check("out_data", out_data, x[7:0]);
            check("out_last", out_last, x[8]);
          end
        end
        prev_stall = !out_ready;
        prev_data  = out_data;
      end else begin
        prev_stall = 1'b0;
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin : stimulus
    int base;
    int g;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    send_vec(64'h40404040_40404040, 64'hFFFFFFFF_FFFFFFFF, 2040, 1'b0);
    wait_idle();
    send_vec(64'h00000000_00000080, 64'h00000000_000000FF, 255, 1'b0);
    wait_idle();
    send_vec(64'h30303030_30301830, 64'hFFFFFFFF_FFFF5FFF, 1880, 1'b0);
    wait_idle();

    bp_mode = 1;
    send_vec(64'h30303030_30301830, 64'hFFFFFFFF_FFFF5FFF, 1880, 1'b0);
    wait_idle();
    bp_mode = 0;

    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h20 + 8'(i);
      g = 0;
      while (!in_ready && g < 200) begin
        @(posedge clk); #1;
        g++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("busy_mid_load", busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("no_sum_after_abort", exp_sum_q.size(), 0);
    send_vec(64'h10101010_10101010, 64'hFFFFFFFF_FFFFFFFF, 2040, 1'b0);
    wait_idle();

    base = sum_cyc.size();
    send_vec(64'h40404040_40404040, 64'hFFFFFFFF_FFFFFFFF, 2040, 1'b1);
    send_vec(64'h00000000_00000080, 64'h00000000_000000FF, 255, 1'b1);
    in_valid = 1'b0;
    wait_idle();
    if (sum_cyc.size() >= base + 2)
      check("b2b_sum_period", sum_cyc[base + 1] - sum_cyc[base], 3 * N + 2);
    else
      timeout_fail("b2b_sum_count");

    check("total_accepts", accepts, 7 * N + 5);
    check("final_busy", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/softmax_exp_accumulator.md
Name: softmax_exp_accumulator

Overview:
Upstream stage of the pseudo-softmax datapath. It feeds the 8-bit reciprocal stage. It takes a vector of N unsigned Q4.4 logits and buffers them while tracking the maximum. It then computes a base-2 pseudo-exponential 2^-(max-x) for each element and accumulates their sum. It presents the scaled sum for the reciprocal stage, then streams the stored exponentials to the downstream normaliser.

Parameters:
N, 8, elements per vector; must be a power of two, 2..16
LOG2N, 3, log2(N); sets sum width and sum scaling

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_data valid
in_ready  output  1  block accepts an element this cycle
in_data  input  8  unsigned logit, Q4.4
sum_valid  output  1  one-cycle pulse when sum_full/sum_q become valid
sum_full  output  8+LOG2N  exact sum of the N exponentials
sum_q  output  8  sum_full >> LOG2N; operand for the reciprocal stage
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts out_data
out_data  output  8  exponential of element i, in input order
out_last  output  1  high with the final (N-th) out_data beat
busy  output  1  high in any state other than LOAD with zero elements taken

Behaviour:
- Reset (async, rst_n=0):
  - state=LOAD, count=0, max=0, acc=0.
  - in_ready=1; sum_valid=0; sum_full=0; sum_q=0.
  - out_valid=0; out_last=0; out_data=0; busy=0.
  - Buffer contents don't-care.
- Reset asserted mid-operation aborts the vector. No partial sum or output beat is emitted after release.
- LOAD:
  - in_ready=1.
  - On in_valid&&in_ready: buf[count]=in_data; max=max(max,in_data); count++.
  - The max comparison includes the current element. Ties keep the value; it is the same either way.
  - After the N-th accept: in_ready drops the next cycle; go to EXP with count=0 and acc=0.
- EXP: exactly N cycles, one element per cycle, in_ready=0.
  - d = max - buf[i]; 8-bit, never negative.
  - k = d[7:4]; f = d[3:0].
  - m = 255 - {f,3'b000}, giving range 255..135.
  - e = (k>=8) ? 0 : (m >> k).
  - buf[i] = e; acc += e.
  - acc width 8+LOG2N, cannot overflow since N*255 < 2^(8+LOG2N).
- EXP exit, on the cycle after the N-th element:
  - sum_full=acc; sum_q=acc>>LOG2N.
  - sum_valid pulses high for exactly one cycle; go to EMIT.
  - sum_full/sum_q hold until the next vector's sum_valid.
  - sum_full >= 255 always, because the max element gives e=255.
- EMIT: stream buf[0..N-1].
  - out_valid=1 with out_data=buf[j].
  - Advance j only on out_valid&&out_ready.
  - out_data and out_valid are stable while stalled.
  - out_last=1 when j==N-1.
  - On the last handshake: out_valid=0 next cycle; go to LOAD with count=0, max=0.
- Timing: in_valid asserted during EXP/EMIT is ignored (in_ready=0); no data is lost or accepted.
- Latency: last input accept to sum_valid = N+1 cycles. sum_valid to first out_valid = 1 cycle (same cycle as EMIT entry).
- Throughput: with no stalls, one vector per 3N+2 cycles. Input is not overlapped with EXP/EMIT.

Test Plan:
- Uniform vector, N=8, all in_data=0x40 -> every e=255; sum_full=2040; sum_q=255; out_data=0xFF x8; out_last on beat 8.
- One-hot, in_data={0x80,0,0,0,0,0,0,0} -> e={255,0 x7}; sum_full=255; sum_q=31.
- PWL check, in_data={0x30,0x18,0x30,0x30,0x30,0x30,0x30,0x30}:
  - element 1 has d=0x18 (k=1, f=8, m=191), so e=95; the others are 255.
  - sum_full=1880; sum_q=235.
- Backpressure: out_ready toggles 1,0,0,1 repeatedly during EMIT -> out_data held during stalls; exactly 8 beats in order; single out_last.
- Reset mid-flight: rst_n low after 5 of 8 accepts, then a fresh uniform 0x10 vector -> no sum_valid from the aborted vector; new sum_full=2040.
- Back-to-back vectors with in_valid held high throughout:
  - in_ready=0 during EXP/EMIT; only 8 accepts per vector.
  - Second vector's sum_valid arrives 3N+2=26 cycles after the first with out_ready=1.
